// File: rtl/player_projectile_if.sv
// -----------------------------------------------------------------------------
// player_projectile_if
// Bundles the player-laser control inputs and projectile outputs.
//   tick           : one-cycle movement enable (frame rate)
//   fire           : debounced fire button, level
//   player_x       : player cannon upper-left x
//   collision      : hit report from the collision stage, level
//   proj_x/proj_y  : projectile coordinates
//   proj_active    : projectile in flight
//   proj_exploding : explosion sprite enable
//   shot_fired     : one-cycle pulse on launch
//   hit            : one-cycle pulse when a flight ends by collision
//   ready          : able to fire
// Modports: slave (the projectile block), master (whoever drives the inputs).
// -----------------------------------------------------------------------------
interface player_projectile_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           tick;
    logic           fire;
    logic [X_W-1:0] player_x;
    logic           collision;
    logic [X_W-1:0] proj_x;
    logic [Y_W-1:0] proj_y;
    logic           proj_active;
    logic           proj_exploding;
    logic           shot_fired;
    logic           hit;
    logic           ready;

    modport slave (
        input  tick, fire, player_x, collision,
        output proj_x, proj_y, proj_active, proj_exploding, shot_fired, hit, ready
    );

    modport master (
        output tick, fire, player_x, collision,
        input  proj_x, proj_y, proj_active, proj_exploding, shot_fired, hit, ready
    );
endinterface

// File: rtl/player_projectile.sv
// -----------------------------------------------------------------------------
// player_projectile
// Launches one player laser per fire-button press from the cannon muzzle and
// moves it up one step per tick. The laser retires on collision or at the top
// of the playfield, then shows an explosion for BURST_TICKS ticks and waits
// COOLDOWN_TICKS ticks before it can fire again.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : player_projectile_if.slave (inputs tick/fire/player_x/collision,
//          registered outputs proj_x/proj_y/proj_active/proj_exploding/
//          shot_fired/hit/ready)
// -----------------------------------------------------------------------------
module player_projectile #(
    parameter int X_W            = 10,
    parameter int Y_W            = 10,
    parameter int GUN_OFFSET     = 7,
    parameter int SPAWN_Y        = 432,
    parameter int PROJ_SPEED     = 4,
    parameter int TOP_LIMIT      = 16,
    parameter int BURST_TICKS    = 4,
    parameter int COOLDOWN_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst,
    player_projectile_if.slave  bus
);

    localparam int CNT_MAX  = (BURST_TICKS > COOLDOWN_TICKS) ? BURST_TICKS : COOLDOWN_TICKS;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // One extra bit so TOP_LIMIT + PROJ_SPEED cannot overflow the compare.
    localparam int FIZZLE_Y = TOP_LIMIT + PROJ_SPEED;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLY      = 2'd1,
        ST_BURST    = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           fire_q;
    logic           shot_q, shot_d;
    logic           hit_q, hit_d;
    logic           active_q, active_d;
    logic           expl_q, expl_d;
    logic           ready_q, ready_d;
    logic           rise_s;

    assign rise_s = bus.fire & ~fire_q;

    // Next-state, coordinate and registered-output decode.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        shot_d  = 1'b0;
        hit_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_FLY;
                    x_d     = bus.player_x + X_W'(GUN_OFFSET);
                    y_d     = Y_W'(SPAWN_Y);
                    cnt_d   = {CNT_W{1'b0}};
                    shot_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLY: begin
                // Collision outranks a same-cycle tick.
                if (bus.collision) begin
                    state_d = ST_BURST;
                    cnt_d   = {CNT_W{1'b0}};
                    hit_d   = 1'b1;
                end else if (bus.tick) begin
                    // Stepping would cross TOP_LIMIT: fizzle in place instead.
                    if ({1'b0, y_q} < (Y_W+1)'(FIZZLE_Y)) begin
                        state_d = ST_BURST;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        y_d = y_q - Y_W'(PROJ_SPEED);
                    end
                end else begin
                    state_d = ST_FLY;
                end
            end
            ST_BURST: begin
                if (bus.tick) begin
                    if (cnt_q == CNT_W'(BURST_TICKS - 1)) begin
                        state_d = ST_COOLDOWN;
                        cnt_d   = {CNT_W{1'b0}};
                        x_d     = {X_W{1'b0}};
                        y_d     = {Y_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_COOLDOWN: begin
                if (bus.tick) begin
                    if (cnt_q == CNT_W'(COOLDOWN_TICKS - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_COOLDOWN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = {X_W{1'b0}};
                y_d     = {Y_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        // Status flags follow the state being entered so they are registered.
        active_d = (state_d == ST_FLY);
        expl_d   = (state_d == ST_BURST);
        ready_d  = (state_d == ST_IDLE);
    end

    // State, coordinate, edge-detect and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= {X_W{1'b0}};
            y_q      <= {Y_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            fire_q   <= 1'b0;
            shot_q   <= 1'b0;
            hit_q    <= 1'b0;
            active_q <= 1'b0;
            expl_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            fire_q   <= bus.fire;
            shot_q   <= shot_d;
            hit_q    <= hit_d;
            active_q <= active_d;
            expl_q   <= expl_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.proj_x         = x_q;
    assign bus.proj_y         = y_q;
    assign bus.proj_active    = active_q;
    assign bus.proj_exploding = expl_q;
    assign bus.shot_fired     = shot_q;
    assign bus.hit            = hit_q;
    assign bus.ready          = ready_q;

endmodule

// File: tb/tb_player_projectile.sv
// -----------------------------------------------------------------------------
// tb_player_projectile
// Directed bench for player_projectile. Expected output snapshots are queued
// as each stimulus step is driven and compared once the DUT has clocked it.
// -----------------------------------------------------------------------------
module tb_player_projectile;

    typedef struct {
        string tag;
        int    x;
        int    y;
        bit    act;
        bit    expl;
        bit    shot;
        bit    hit;
        bit    rdy;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    player_projectile_if #(.X_W(10), .Y_W(10)) pif ();

    player_projectile dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input int x, input int y, input bit act,
                        input bit expl, input bit shot, input bit hit, input bit rdy);
        exp_t e;
        e.tag = tag; e.x = x; e.y = y; e.act = act;
        e.expl = expl; e.shot = shot; e.hit = hit; e.rdy = rdy;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".proj_x"},         pif.proj_x,         e.x);
            chk({e.tag, ".proj_y"},         pif.proj_y,         e.y);
            chk({e.tag, ".proj_active"},    pif.proj_active,    32'(e.act));
            chk({e.tag, ".proj_exploding"}, pif.proj_exploding, 32'(e.expl));
            chk({e.tag, ".shot_fired"},     pif.shot_fired,     32'(e.shot));
            chk({e.tag, ".hit"},            pif.hit,            32'(e.hit));
            chk({e.tag, ".ready"},          pif.ready,          32'(e.rdy));
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            pif.tick = 1'b1;
            step();
            pif.tick = 1'b0;
            step();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        pif.tick      = 1'b0;
        pif.fire      = 1'b0;
        pif.collision = 1'b0;
        pif.player_x  = 10'd0;

        // Reset state
        push("reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); step();
        pop_check();
        rst = 1'b0;
        step();

        // Launch with a same-cycle tick: spawn coordinates, no movement
        pif.player_x = 10'd300;
        pif.fire     = 1'b1;
        pif.tick     = 1'b1;
        push("launch", 307, 432, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        pop_check();
        pif.tick = 1'b0;
        push("launch_pulse_end", 307, 432, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_check();

        // Free flight with fire held high the whole time
        tick_n(10);
        push("fly10", 307, 392, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_check();
        tick_n(94);
        push("fly104", 307, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_check();

        // Top-of-screen fizzle: no hit, y held at 16
        pif.tick = 1'b1;
        push("fizzle", 307, 16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        pop_check();
        pif.tick = 1'b0;
        tick_n(3);
        push("burst3", 307, 16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pop_check();
        pif.tick = 1'b1;
        push("to_cooldown", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_check();
        pif.tick = 1'b0;

        // Collision in cooldown ignored; 8th tick re-arms
        pif.collision = 1'b1;
        tick_n(7);
        push("cooldown7", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_check();
        pif.tick = 1'b1;
        push("rearm", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        pop_check();
        pif.tick = 1'b0;
        push("held_fire_idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        pop_check();
        pif.collision = 1'b0;
        pif.fire      = 1'b0;
        step();

        // Fresh press after release launches
        pif.player_x = 10'd100;
        pif.fire     = 1'b1;
        push("relaunch", 107, 432, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        pop_check();
        pif.fire = 1'b0;
        tick_n(5);
        push("fly5", 107, 412, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_check();

        // Press during flight is dropped
        pif.fire = 1'b1;
        push("fire_in_fly", 107, 412, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_check();
        pif.fire = 1'b0;
        step();

        // Collision together with tick: collision wins, hit pulse
        pif.collision = 1'b1;
        pif.tick      = 1'b1;
        push("collide", 107, 412, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        pop_check();
        pif.collision = 1'b0;
        pif.tick      = 1'b0;
        push("hit_pulse_end", 107, 412, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        pop_check();
        tick_n(3);
        push("cburst3", 107, 412, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pop_check();
        tick_n(1);
        push("cburst4", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_check();

        // Press during cooldown is dropped
        pif.fire = 1'b1;
        push("fire_in_cool", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_check();
        pif.fire = 1'b0;
        tick_n(8);
        push("cool_rearm", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pop_check();

        // Reset mid-flight at y=300
        pif.player_x = 10'd200;
        pif.fire     = 1'b1;
        push("launch3", 207, 432, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        pop_check();
        pif.fire = 1'b0;
        tick_n(33);
        push("fly33", 207, 300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_check();
        rst = 1'b1;
        push("rst_fly", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        pop_check();
        rst = 1'b0;
        pif.fire = 1'b1;
        push("launch_after_rst", 207, 432, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        pop_check();
        pif.fire = 1'b0;
        step();

        // Reset cancels a pending hit pulse
        pif.collision = 1'b1;
        rst           = 1'b1;
        push("rst_cancels_hit", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        pop_check();
        rst           = 1'b0;
        pif.collision = 1'b0;
        push("after_rst_idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        pop_check();

        // Muzzle x truncates to X_W bits: 1020 + 7 = 1027 -> 3
        pif.player_x = 10'd1020;
        pif.fire     = 1'b1;
        push("launch_wrap_x", 3, 432, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        pop_check();
        pif.fire = 1'b0;

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_projectile.md
# player_projectile

Upstream source of the projectile coordinates consumed by the collision stage. Launches one player laser per fire-button press from the cannon muzzle and moves it up the screen one step per movement tick. The laser retires on a collision report or on reaching the top of the playfield, then runs a short explosion phase and a re-arm cooldown. Only one projectile exists at a time.

## Interface
- X_W, 10: width of x coordinates
- Y_W, 10: width of y coordinates
- GUN_OFFSET, 7: muzzle x offset added to player_x at spawn
- SPAWN_Y, 432: proj_y at launch (cannon top minus projectile height)
- PROJ_SPEED, 4: pixels moved up per tick
- TOP_LIMIT, 16: smallest legal proj_y; the projectile never goes below this value
- BURST_TICKS, 4: ticks spent in explosion phase (>=1)
- COOLDOWN_TICKS, 8: ticks before re-arm (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle movement enable pulse (frame rate)
- fire  in  1  debounced fire button, level
- player_x  in  X_W  player cannon upper-left x
- collision  in  1  hit report from the collision stage, level
- proj_x  out  X_W  projectile x
- proj_y  out  Y_W  projectile y
- proj_active  out  1  projectile in flight; collision is honoured only while this is 1
- proj_exploding  out  1  explosion sprite enable
- shot_fired  out  1  one-cycle pulse on launch
- hit  out  1  one-cycle pulse when a flight ends by collision
- ready  out  1  high in IDLE (able to fire)

## Operation
- FSM states: IDLE, FLY, BURST, COOLDOWN.
- Rising-edge detect: fire_q is fire registered one cycle earlier. rise = fire & ~fire_q. fire_q resets to 0.
- IDLE:
  - On rise: go to FLY, load proj_x = player_x + GUN_OFFSET (truncated to X_W), load proj_y = SPAWN_Y, pulse shot_fired.
  - A rise in any other state is dropped, not queued. Holding fire never re-fires; the button must be released and pressed again.
- FLY, evaluated every cycle, in priority order:
  1. collision=1: go to BURST, pulse hit, freeze proj_x/proj_y.
  2. Else, on tick:
     - If proj_y < TOP_LIMIT + PROJ_SPEED: go to BURST with proj_y held and no hit pulse (top-of-screen fizzle).
     - Otherwise proj_y <= proj_y - PROJ_SPEED.
  - Unsigned arithmetic never wraps; the guard above prevents underflow.
- BURST:
  - proj_exploding=1. Coordinates are held so the explosion is drawn at the impact point.
  - Tick counter counts BURST_TICKS ticks. Then go to COOLDOWN and set proj_x = proj_y = 0.
- COOLDOWN: count COOLDOWN_TICKS ticks, then go to IDLE.
- Tick counter clears on every state entry.
- Outputs by state:
  - proj_active = (state==FLY)
  - ready = (state==IDLE)
  - proj_exploding = (state==BURST)
- collision is ignored outside FLY.

## Timing
- Reset values: state IDLE, proj_x=0, proj_y=0, proj_active=0, proj_exploding=0, shot_fired=0, hit=0, ready=1, counter 0, fire_q 0.
- Reset mid-flight or mid-burst returns to IDLE the next cycle with all outputs at reset values. Any pending pulse is cancelled.
- Launch latency: fire rises at cycle N (fire_q still 0). At N+1: state FLY, coordinates loaded, shot_fired=1 for exactly that cycle.
- Motion: proj_y updates the cycle after the tick pulse. No movement occurs in the cycle that loads spawn coordinates, even if tick=1 in cycle N.
- Collision at cycle N in FLY:
  - At N+1: BURST, hit=1 for one cycle, proj_active=0.
  - A tick in the same cycle N is ignored (collision wins).
- Flight ends at cycle N. After that, the BURST and COOLDOWN ticks must both be counted before ready=1; the earliest relaunch is one cycle after that.
- All outputs are registered.

## Test plan
- Reset, then player_x=300, fire rising -> next cycle proj_x=307, proj_y=432, proj_active=1, shot_fired high for exactly 1 cycle, ready=0.
- Free flight: after launch, 10 ticks -> proj_y=392. After 104 ticks total -> proj_y=16. Next tick: no hit pulse, BURST entered at proj_y=16 (never wraps). Then 4 ticks to COOLDOWN with coords 0. Then 8 ticks to IDLE, ready=1.
- Collision after 5 ticks (proj_y=412), asserted together with a tick -> BURST next cycle, hit pulse, proj_y stays 412, proj_exploding=1 for 4 ticks.
- Fire held high through an entire flight and cooldown -> no second launch. Release, then press -> launch occurs.
- Fire pressed during FLY and COOLDOWN -> ignored; no shot_fired. collision=1 in IDLE or COOLDOWN -> no hit, no state change.
- rst asserted mid-FLY (proj_y=300) -> next cycle IDLE, proj_x=proj_y=0, proj_active=0, ready=1. A fresh press launches normally.
